uart_imem_loader: RTL and testbench

Parametrised boot loader between the UART receiver and the core's instruction memory. It assembles received bytes little-endian into DATA_W-bit words and writes them to consecutive instruction-memory addresses from 0. Loading ends on an all-ones end-marker word. While loading, the core is held in reset; when loading completes, the block releases the core and asserts write_done.

---
 rtl/uart_imem_loader_if.sv | 28 ++
 rtl/uart_imem_loader.sv | 129 ++++++++++++
 tb/tb_uart_imem_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// Boot-loader bus: UART byte stream and reload into the loader, imem write port and load status out.
interface uart_imem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              uart_rx_en;
  logic              uart_rx_valid;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_break;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              cpu_rst;
  logic              write_done;
  logic              load_err;

  modport master (
    output uart_rx_en, uart_rx_valid, uart_rx_data, uart_rx_break, reload,
    input  imem_we, imem_addr, imem_wdata, word_count, cpu_rst, write_done, load_err
  );

  modport slave (
    input  uart_rx_en, uart_rx_valid, uart_rx_data, uart_rx_break, reload,
    output imem_we, imem_addr, imem_wdata, word_count, cpu_rst, write_done, load_err
  );
endinterface

// File: rtl/uart_imem_loader.sv
// Packs UART bytes little-endian into imem words from address 0; write strobe 1 cycle after the last byte, no backpressure.
// An all-ones word ends the load; LOADER_CHECKSUM_EN adds a trailing modulo-256 sum byte check.
module uart_imem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  uart_imem_loader_if.slave bus
);
  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_LOAD, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERR} state_t;
`endif

  state_t            state, state_next;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] word_buf;
  logic [DATA_W-1:0] asm_word;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              accept, last_byte, full;
  logic              take_byte, do_write, clear;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] byte_sum(input logic [DATA_W-1:0] w);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s = s + w[8*i +: 8];
    return s;
  endfunction
`endif

  assign accept    = bus.uart_rx_valid & bus.uart_rx_en;
  assign last_byte = (byte_cnt == BC_W'(NB - 1));
  assign full      = word_count[ADDR_W];

  always_comb begin
    state_next = state;
    take_byte  = 1'b0;
    do_write   = 1'b0;
    clear      = 1'b0;
    asm_word   = word_buf;
    asm_word[{byte_cnt, 3'b000} +: 8] = bus.uart_rx_data;
    case (state)
      S_LOAD: begin
        // break outranks a byte arriving in the same cycle
        if (bus.uart_rx_break) begin
          state_next = S_ERR;
        end else if (accept) begin
          take_byte = 1'b1;
          if (last_byte) begin
            if (&asm_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_next = S_CSUM;
`else
              state_next = S_DONE;
`endif
            end else if (full) begin
              state_next = S_ERR;
            end else begin
              do_write = 1'b1;
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (bus.uart_rx_break) state_next = S_ERR;
        else if (accept) state_next = (bus.uart_rx_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (bus.reload) begin
          state_next = S_LOAD;
          clear      = 1'b1;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= S_LOAD;
      byte_cnt   <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state   <= state_next;
      imem_we <= do_write;
      // imem_addr trails word_count by a cycle so it holds the written address during the strobe
      if (!full) imem_addr <= word_count[ADDR_W-1:0];
      if (do_write) begin
        imem_wdata <= asm_word;
        word_count <= word_count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum       <= csum + byte_sum(asm_word);
`endif
      end
      if (take_byte) begin
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        word_buf <= last_byte ? '0 : asm_word;
      end
    end
  end

  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wdata = imem_wdata;
  assign bus.word_count = word_count;
  assign bus.cpu_rst    = (state != S_DONE);
  assign bus.write_done = (state == S_DONE);
  assign bus.load_err   = (state == S_ERR);
endmodule

// File: tb/tb_uart_imem_loader.sv
// Drives two loaders (1024-word and 4-word imem) with the same byte stream and checks both against a byte-queue model.
module tb_uart_imem_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_imem_loader_if #(.DATA_W(32), .ADDR_W(10)) ifa ();
  uart_imem_loader_if #(.DATA_W(32), .ADDR_W(2))  ifb ();

  uart_imem_loader #(.DATA_W(32), .ADDR_W(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  uart_imem_loader #(.DATA_W(32), .ADDR_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int          total = 0;
  int          bad   = 0;
  int          ev[$];             // accepted bytes (0..255) and breaks (-1), in order
  logic [63:0] got_a[$], got_b[$], mq[$];
  logic [7:0]  tb_sum;
`ifdef LOADER_CHECKSUM_EN
  logic        corrupt;
`endif

  always @(negedge clk) begin
    if (ifa.imem_we === 1'b1) got_a.push_back({32'(ifa.imem_addr), ifa.imem_wdata});
    if (ifb.imem_we === 1'b1) got_b.push_back({32'(ifb.imem_addr), ifb.imem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: whole-stream interpretation of the loader rules.
  // st: 0 loading, 1 awaiting checksum, 2 done, 3 error.
  function automatic void model(input int cap, output int st, output int cnt);
    int          cur[$];
    logic [31:0] w;
    logic [7:0]  sum;
    mq.delete();
    st = 0; cnt = 0; sum = 8'd0;
    foreach (ev[i]) begin
      if (st >= 2) continue;
      if (ev[i] < 0) begin st = 3; continue; end
      if (st == 1) begin st = (ev[i] == int'(sum)) ? 2 : 3; continue; end
      cur.push_back(ev[i]);
      if (cur.size() == 4) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++) w = w | (32'(cur[k]) << (8 * k));
        cur.delete();
        if (w == 32'hffffffff) begin
`ifdef LOADER_CHECKSUM_EN
          st = 1;
`else
          st = 2;
`endif
        end else if (cnt == cap) begin
          st = 3;
        end else begin
          mq.push_back({32'(cnt), w});
          for (int k = 0; k < 4; k++) sum = sum + w[8*k +: 8];
          cnt++;
        end
      end
    end
  endfunction

  task automatic set_in(input logic v, input logic [7:0] d, input logic en, input logic brk, input logic rl);
    ifa.uart_rx_valid = v; ifa.uart_rx_data = d; ifa.uart_rx_en = en; ifa.uart_rx_break = brk; ifa.reload = rl;
    ifb.uart_rx_valid = v; ifb.uart_rx_data = d; ifb.uart_rx_en = en; ifb.uart_rx_break = brk; ifb.reload = rl;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic en, input logic brk, input int gap);
    set_in(1'b1, b, en, brk, 1'b0);
    if (brk) ev.push_back(-1);
    else if (en) ev.push_back(int'(b));
    @(negedge clk);
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_break();
    set_in(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    ev.push_back(-1);
    @(negedge clk);
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_reload();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      tb_sum += b;
      drive_byte(b, 1'b1, 1'b0, rnd ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic send_marker();
    repeat (4) drive_byte(8'hff, 1'b1, 1'b0, 0);
`ifdef LOADER_CHECKSUM_EN
    drive_byte(corrupt ? tb_sum + 8'd1 : tb_sum, 1'b1, 1'b0, 0);
`endif
  endtask

  task automatic restart();
    rst = 1'b1;
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ev.delete(); got_a.delete(); got_b.delete();
    tb_sum = 8'd0;
  endtask

  task automatic reload_restart(input string tag);
    pulse_reload();
    ev.delete(); got_a.delete(); got_b.delete();
    tb_sum = 8'd0;
    check({tag, ".rl.cpu_rst"}, 64'(ifa.cpu_rst), 64'd1);
    check({tag, ".rl.done"},    64'(ifa.write_done), 64'd0);
    check({tag, ".rl.err"},     64'(ifb.load_err), 64'd0);
    check({tag, ".rl.cnt"},     64'(ifa.word_count), 64'd0);
    check({tag, ".rl.addr"},    64'(ifa.imem_addr), 64'd0);
  endtask

  task automatic verify(input string tag);
    int st, cnt;
    repeat (3) @(negedge clk);
    model(1024, st, cnt);
    check({tag, ".a.nwr"}, 64'(got_a.size()), 64'(mq.size()));
    for (int i = 0; i < mq.size() && i < got_a.size(); i++) check({tag, ".a.wr"}, got_a[i], mq[i]);
    check({tag, ".a.cnt"},  64'(ifa.word_count), 64'(cnt));
    check({tag, ".a.done"}, 64'(ifa.write_done), 64'(st == 2));
    check({tag, ".a.err"},  64'(ifa.load_err), 64'(st == 3));
    check({tag, ".a.crst"}, 64'(ifa.cpu_rst), 64'(st != 2));
    model(4, st, cnt);
    check({tag, ".b.nwr"}, 64'(got_b.size()), 64'(mq.size()));
    for (int i = 0; i < mq.size() && i < got_b.size(); i++) check({tag, ".b.wr"}, got_b[i], mq[i]);
    check({tag, ".b.cnt"},  64'(ifb.word_count), 64'(cnt));
    check({tag, ".b.done"}, 64'(ifb.write_done), 64'(st == 2));
    check({tag, ".b.err"},  64'(ifb.load_err), 64'(st == 3));
    check({tag, ".b.crst"}, 64'(ifb.cpu_rst), 64'(st != 2));
  endtask

  initial begin
    int          nw;
    logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
    corrupt = 1'b0;
`endif
    tb_sum = 8'd0;
    rst = 1'b1;
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst.we",   64'(ifa.imem_we), 64'd0);
    check("rst.addr", 64'(ifa.imem_addr), 64'd0);
    check("rst.data", 64'(ifa.imem_wdata), 64'd0);
    check("rst.cnt",  64'(ifa.word_count), 64'd0);
    check("rst.crst", 64'(ifa.cpu_rst), 64'd1);
    check("rst.done", 64'(ifa.write_done), 64'd0);
    check("rst.err",  64'(ifb.load_err), 64'd0);
    restart();

    // single word, then marker
    send_word(32'hfc010113, 1'b0);
    check("t1.we",   64'(ifa.imem_we), 64'd1);
    check("t1.addr", 64'(ifa.imem_addr), 64'd0);
    check("t1.data", 64'(ifa.imem_wdata), 64'hfc010113);
    @(negedge clk);
    check("t1.we_off", 64'(ifa.imem_we), 64'd0);
    check("t1.addr_inc", 64'(ifa.imem_addr), 64'd1);
    check("t1.crst_load", 64'(ifa.cpu_rst), 64'd1);
    send_marker();
    check("t1.done_lat", 64'(ifa.write_done), 64'd1);
    check("t1.crst_lat", 64'(ifa.cpu_rst), 64'd0);
    verify("t1");
    reload_restart("t1");

    // three words with an ignored reload mid-load
    send_word(32'h00000000, 1'b0);
    pulse_reload();
    send_word(32'hfc010113, 1'b0);
    send_word(32'h02812e23, 1'b0);
    send_marker();
    verify("t2");
    reload_restart("t2");

    // break mid-word, then reload and load again
    drive_byte(8'h13, 1'b1, 1'b0, 0);
    drive_byte(8'h01, 1'b1, 1'b0, 0);
    pulse_break();
    check("t3.err_lat", 64'(ifa.load_err), 64'd1);
    check("t3.crst",    64'(ifa.cpu_rst), 64'd1);
    verify("t3");
    reload_restart("t3");
    send_word(32'h00500093, 1'b0);
    send_marker();
    verify("t3b");
    reload_restart("t3b");

    // five words overflow the 4-word imem
    for (int i = 0; i < 5; i++) send_word(32'h0a0b0c00 + 32'(i), 1'b0);
    check("t4.b_err", 64'(ifb.load_err), 64'd1);
    check("t4.b_we",  64'(ifb.imem_we), 64'd0);
    check("t4.a_we",  64'(ifa.imem_we), 64'd1);
    check("t4.a_addr", 64'(ifa.imem_addr), 64'd4);
    send_marker();
    verify("t4");
    restart();

`ifdef LOADER_CHECKSUM_EN
    send_word(32'h04010413, 1'b0);
    repeat (4) drive_byte(8'hff, 1'b1, 1'b0, 0);
    drive_byte(8'h1c, 1'b1, 1'b0, 0);
    check("cs.good", 64'(ifa.write_done), 64'd1);
    verify("cs1");
    reload_restart("cs1");
    send_word(32'h04010413, 1'b0);
    repeat (4) drive_byte(8'hff, 1'b1, 1'b0, 0);
    drive_byte(8'h1d, 1'b1, 1'b0, 0);
    check("cs.bad", 64'(ifa.load_err), 64'd1);
    verify("cs2");
    restart();
`endif

    // reset mid-word discards the partial bytes
    drive_byte(8'haa, 1'b1, 1'b0, 0);
    drive_byte(8'hbb, 1'b1, 1'b0, 0);
    restart();
    send_word(32'h11223344, 1'b0);
    send_marker();
    check("t5.data", (got_a.size() > 0) ? got_a[0] : 64'hdead, {32'd0, 32'h11223344});
    verify("t5");
    restart();

    for (int it = 0; it < 10; it++) begin
      nw = int'($urandom_range(0, 6));
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        if (w == 32'hffffffff) w = 32'd0;
        send_word(w, 1'b1);
        if ($urandom_range(0, 3) == 0) drive_byte(8'($urandom), 1'b0, 1'b0, 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) drive_byte(8'($urandom), 1'b1, 1'b0, 0);
        if ($urandom_range(0, 1) == 0) pulse_break();
        else drive_byte(8'($urandom), 1'b1, 1'b1, 0);
      end else begin
`ifdef LOADER_CHECKSUM_EN
        corrupt = ($urandom_range(0, 3) == 0);
`endif
        send_marker();
      end
      repeat (2) drive_byte(8'($urandom), 1'b1, 1'b0, 0);
      verify("rnd");
      restart();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
